fibo_uart_tx: RTL and testbench

//   Downstream consumer of the fibo_led 8-bit out bus. Detects each change of the

---
 rtl/fibo_uart_tx.sv | 159 +++++++++++++++
 tb/tb_fibo_uart_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fibo_uart_tx.sv
// Serialises every change of the fibo_led value as one UART frame, LSB first.
// Define FIBO_UART_PARITY_EN to append an even-parity bit after D7 (8E1 instead of 8N1).
module fibo_uart_tx #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [15:0] BAUD_LAST = CLKS_PER_BIT - 16'd1;

    state_e      state_q, state_d;
    logic [7:0]  last_q, last_d;
    logic [7:0]  pend_q, pend_d;
    logic        pending_q, pending_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;

    logic        chg;
    logic        baud_end;

    assign chg      = (din != last_q);
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        shift_d   = shift_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ovr_d     = 1'b0;

        // A change during a frame is parked; a second one replaces it.
        if (state_q != IDLE) begin
            baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
            if (chg) begin
                pend_d    = din;
                last_d    = din;
                pending_d = 1'b1;
                ovr_d     = pending_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                if (chg) begin
                    shift_d   = din;
                    last_d    = din;
                    pending_d = 1'b0;
                    ovr_d     = pending_q;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end else if (pending_q) begin
                    shift_d   = pend_q;
                    pending_d = 1'b0;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
`ifdef FIBO_UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end
            end
`ifdef FIBO_UART_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 8'h00;
            pend_q    <= 8'h00;
            pending_q <= 1'b0;
            shift_q   <= 8'h00;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_fibo_uart_tx.sv
// Directed bench for fibo_uart_tx at 4 clocks per bit.
// Frames are decoded from tx by mid-bit sampling on falling clock edges.
module tb_fibo_uart_tx;

    localparam int C = 4;
`ifdef FIBO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = 8'hA5;
    logic       tx;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int ovr_cyc = 0;

    fibo_uart_tx #(
        .CLKS_PER_BIT(16'd4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .tx     (tx),
        .busy   (busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overrun) ovr_cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rx_frame(output logic [7:0] d, output logic p,
                            output int bz, output int w, output logic ok);
        int j;
        d  = 8'h00;
        p  = 1'b0;
        bz = 0;
        w  = 0;
        ok = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (tx && w < 400);
        if (tx) begin
            ok = 1'b0;
            return;
        end
        for (int k = 0; k <= NB * C; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) bz++;
            if (k % C == C / 2) begin
                j = k / C;
                if (j == 0 && tx) ok = 1'b0;
                if (j >= 1 && j <= 8) d[j-1] = tx;
                if (NB == 11 && j == 9) p = tx;
                if (j == NB - 1 && !tx) ok = 1'b0;
            end
        end
    endtask

    task automatic idle_wait(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!tx || busy) bad++;
        end
    endtask

    logic [7:0] d;
    logic       p;
    logic       ok;
    int         bz;
    int         w;
    int         bad;
    int         ovr0;

    initial begin
        // reset held with a non-zero din
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!tx || busy || overrun) bad++;
        end
        chk("rst_hold", bad, 0);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);

        din = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        idle_wait(8, bad);
        chk("post_rst_idle", bad, 0);

        // 05 frame, 08 arrives at frame cycle 10
        din = 8'h05;
        fork
            rx_frame(d, p, bz, w, ok);
            begin
                repeat (11) @(negedge clk);
                din = 8'h08;
            end
        join
        chk("f05_lat", w, 1);
        chk("f05_ok", ok, 1);
        chk("f05_data", d, 8'h05);
        chk("f05_busy", bz, NB * C);

        rx_frame(d, p, bz, w, ok);
        chk("f08_gap", w, 1);
        chk("f08_ok", ok, 1);
        chk("f08_data", d, 8'h08);
        chk("f08_busy", bz, NB * C);
        chk("ovr_none", ovr_cyc, 0);

        // 01 frame, then 02 and 03 both mid-frame
        ovr0 = ovr_cyc;
        din = 8'h01;
        fork
            rx_frame(d, p, bz, w, ok);
            begin
                repeat (6) @(negedge clk);
                din = 8'h02;
                repeat (5) @(negedge clk);
                din = 8'h03;
            end
        join
        chk("f01_data", d, 8'h01);
        chk("f01_ok", ok, 1);
        rx_frame(d, p, bz, w, ok);
        chk("f03_gap", w, 1);
        chk("f03_data", d, 8'h03);
        chk("f03_ok", ok, 1);
        chk("ovr_pulse", ovr_cyc - ovr0, 1);
        idle_wait(60, bad);
        chk("no_f02", bad, 0);

        // parity patterns
        din = 8'h07;
        rx_frame(d, p, bz, w, ok);
        chk("f07_data", d, 8'h07);
        chk("f07_busy", bz, NB * C);
`ifdef FIBO_UART_PARITY_EN
        chk("f07_par", p, 1);
`endif
        din = 8'h03;
        rx_frame(d, p, bz, w, ok);
        chk("f03b_data", d, 8'h03);
        chk("f03b_ok", ok, 1);
`ifdef FIBO_UART_PARITY_EN
        chk("f03b_par", p, 0);
`endif

        // abort at frame cycle 17
        idle_wait(3, bad);
        din = 8'h3C;
        repeat (18) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        reset = 1'b0;
        din = 8'h00;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_wait(60, bad);
        chk("abort_idle", bad, 0);
        chk("ovr_total", ovr_cyc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
